// File: rtl/jtcop_paldma_pkg.sv
// Shared constants and state encoding for the palette DMA block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jtcop_paldma_pkg;

    localparam int PAL_ENTRIES = 1024;          // entries per colour table
    localparam int CNT_W       = 10;            // entry counter width
    localparam int B_OFFSET    = PAL_ENTRIES;   // B table follows the RG table in source space
    localparam logic [CNT_W-1:0] LAST_ENTRY = CNT_W'(PAL_ENTRIES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RD_GR = 3'd2,
        ST_WR_GR = 3'd3,
        ST_RD_B  = 3'd4,
        ST_WR_B  = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

endpackage

// File: rtl/jtcop_paldma_if.sv
// Source-read and palette-write buses of the palette DMA.
// Latency: n/a (wiring only).
// Backpressure: source side holds src_cs until src_ok; palette side is write-only.
// Ports: master = DMA engine, slave = source memory plus palette RAM.
interface jtcop_paldma_if
    import jtcop_paldma_pkg::*;
#(
    parameter int SRCW = 11
);
    logic [SRCW-1:0]  src_addr;
    logic             src_cs;
    logic [15:0]      src_data;
    logic             src_ok;
    logic [CNT_W-1:0] pal_addr;
    logic [15:0]      pal_gr;
    logic [7:0]       pal_b;
    logic [1:0]       we_gr;
    logic             we_b;

    modport master (
        output src_addr, src_cs, pal_addr, pal_gr, pal_b, we_gr, we_b,
        input  src_data, src_ok
    );

    modport slave (
        input  src_addr, src_cs, pal_addr, pal_gr, pal_b, we_gr, we_b,
        output src_data, src_ok
    );

endinterface

// File: rtl/jtcop_paldma_rd.sv
// Source-read handshake: raises src_cs on a request, holds it and the address until src_ok.
// Latency: src_cs registered one cycle after req_i; data latched on the src_ok cycle.
// Backpressure: waits indefinitely for src_ok; src_ok without an open request is ignored.
// Ports: req_i/addr_i from the FSM; src_* to the source; ack_o/data_o back to the FSM.
module jtcop_paldma_rd #(
    parameter int SRCW = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_i,
    input  logic [SRCW-1:0] addr_i,
    input  logic            src_ok_i,
    input  logic [15:0]     src_data_i,
    output logic            src_cs_o,
    output logic [SRCW-1:0] src_addr_o,
    output logic            ack_o,
    output logic [15:0]     data_o
);

    logic            cs_q;
    logic [SRCW-1:0] addr_q;
    logic [15:0]     data_q;

    // Only an ack against an open request counts.
    assign ack_o = cs_q & src_ok_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (ack_o) begin
            // Dropping cs here guarantees at least one idle cycle before the next read.
            cs_q   <= 1'b0;
            data_q <= src_data_i;
        end else if (req_i) begin
            cs_q   <= 1'b1;
            addr_q <= addr_i;
        end
    end

    assign src_cs_o   = cs_q;
    assign src_addr_o = addr_q;
    assign data_o     = data_q;

endmodule

// File: rtl/jtcop_paldma.sv
// Palette DMA: copies the RG table then the B table from source memory into palette RAM during vblank.
// Latency: 3 cycles per entry with a 1-cycle source ack; first read 1 cycle after LVBL is seen low.
// Backpressure: stalls on src_ok; pauses before a new read while LVBL=1, finishing any open read first.
// Ports: clk/rst, start (arm), LVBL (active-low blank), busy/done status, bus = source + palette buses.
module jtcop_paldma
    import jtcop_paldma_pkg::*;
#(
    parameter int SRCW = 11
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  logic  LVBL,
    output logic  busy,
    output logic  done,
    jtcop_paldma_if.master bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_req;
    logic [SRCW-1:0]  rd_addr;
    logic             rd_cs;
    logic             rd_ack;
    logic [15:0]      rd_data;
    logic [SRCW-1:0]  rd_src_addr;

    logic             busy_q, done_q, we_b_q;
    logic [1:0]       we_gr_q;
    logic [CNT_W-1:0] pal_addr_q;

    jtcop_paldma_rd #(.SRCW(SRCW)) u_rd (
        .clk        (clk),
        .rst        (rst),
        .req_i      (rd_req),
        .addr_i     (rd_addr),
        .src_ok_i   (bus.src_ok),
        .src_data_i (bus.src_data),
        .src_cs_o   (rd_cs),
        .src_addr_o (rd_src_addr),
        .ack_o      (rd_ack),
        .data_o     (rd_data)
    );

    // A read is launched on the same edge that enters RD_*, which is what keeps
    // an entry at 3 cycles. If blank has ended, the RD_* state waits with cs low
    // and launches the read itself once LVBL returns to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_req  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (!LVBL) begin
                    state_d = ST_RD_GR;
                    cnt_d   = '0;
                    rd_req  = 1'b1;
                end
            end
            ST_RD_GR, ST_RD_B: begin
                if (rd_ack) begin
                    state_d = (state_q == ST_RD_GR) ? ST_WR_GR : ST_WR_B;
                end else if (!rd_cs && !LVBL) begin
                    rd_req = 1'b1;
                end
            end
            ST_WR_GR: begin
                if (cnt_q == LAST_ENTRY) begin
                    state_d = ST_RD_B;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_RD_GR;
                    cnt_d   = cnt_q + 1'b1;
                end
                rd_req = !LVBL;
            end
            ST_WR_B: begin
                if (cnt_q == LAST_ENTRY) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_RD_B;
                    cnt_d   = cnt_q + 1'b1;
                    rd_req  = !LVBL;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Source address of the read being launched: B entries sit above the RG table.
    assign rd_addr = SRCW'(cnt_d) + ((state_d == ST_RD_B) ? SRCW'(B_OFFSET) : '0);

    // Status and write strobes are decoded from the next state so they are plain
    // flops aligned with the state they describe; src_ok never reaches we_* combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_gr_q    <= 2'b00;
            we_b_q     <= 1'b0;
            pal_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= (state_d != ST_IDLE) && (state_d != ST_FIN);
            done_q     <= (state_d == ST_FIN);
            we_gr_q    <= {2{state_d == ST_WR_GR}};
            we_b_q     <= (state_d == ST_WR_B);
            pal_addr_q <= cnt_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign bus.src_cs   = rd_cs;
    assign bus.src_addr = rd_src_addr;
    assign bus.pal_addr = pal_addr_q;
    assign bus.pal_gr   = rd_data;
    assign bus.pal_b    = rd_data[7:0];
    assign bus.we_gr    = we_gr_q;
    assign bus.we_b     = we_b_q;

endmodule
